// File: rtl/audio_lpf.sv
// ============================================================================
//  Module      : audio_lpf
//  Description : Stereo one-pole IIR low-pass stage, y += (x - y) >>> k,
//                with bypass, clear and an rts/rtr handshake on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_lpf #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rf_filt_en,
    input  logic [3:0]      rf_filt_shift,
    input  logic            trig_filt_clr,
    input  logic [2*DW-1:0] filt_in_data,
    input  logic            filt_in_rts,
    output logic            filt_in_rtr,
    output logic [2*DW-1:0] filt_out_data,
    output logic            filt_out_rts,
    input  logic            filt_out_rtr,
    output logic [15:0]     ro_sample_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                r_state;
    logic signed [DW-1:0]  r_x_l;
    logic signed [DW-1:0]  r_x_r;
    logic signed [DW-1:0]  r_y_l;
    logic signed [DW-1:0]  r_y_r;
    logic [2*DW-1:0]       r_out_data;
    logic [15:0]           r_sample_cnt;
    logic                  r_clr_pend;

    logic signed [DW-1:0]  w_y_l_base;
    logic signed [DW-1:0]  w_y_r_base;
    logic signed [DW-1:0]  w_y_l_new;
    logic signed [DW-1:0]  w_y_r_new;

    // The new value always lies between y and x, so truncating back to DW
    // bits can never wrap.
    function automatic logic signed [DW-1:0] lpf_step(
        input logic signed [DW-1:0] x,
        input logic signed [DW-1:0] y,
        input logic [3:0]           k
    );
        logic signed [DW:0] diff;
        logic signed [DW:0] step;
        logic signed [DW:0] sum;
        diff = {x[DW-1], x} - {y[DW-1], y};
        step = diff >>> k;
        sum  = {y[DW-1], y} + step;
        return sum[DW-1:0];
    endfunction

    assign w_y_l_base = r_clr_pend ? '0 : r_y_l;
    assign w_y_r_base = r_clr_pend ? '0 : r_y_r;
    assign w_y_l_new  = rf_filt_en ? lpf_step(r_x_l, w_y_l_base, rf_filt_shift) : r_x_l;
    assign w_y_r_new  = rf_filt_en ? lpf_step(r_x_r, w_y_r_base, rf_filt_shift) : r_x_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_x_l        <= '0;
            r_x_r        <= '0;
            r_y_l        <= '0;
            r_y_r        <= '0;
            r_out_data   <= '0;
            r_sample_cnt <= '0;
            r_clr_pend   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (filt_in_rts) begin
                        r_x_l   <= filt_in_data[2*DW-1:DW];
                        r_x_r   <= filt_in_data[DW-1:0];
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_out_data <= {w_y_l_new, w_y_r_new};
                    r_y_l      <= w_y_l_new;
                    r_y_r      <= w_y_r_new;
                    r_clr_pend <= 1'b0;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (filt_out_rtr) begin
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Placed last so a clear overrides a coincident increment and
            // re-arms the flag even if it lands in CALC.
            if (trig_filt_clr) begin
                r_clr_pend   <= 1'b1;
                r_sample_cnt <= '0;
            end
        end
    end

    assign filt_in_rtr   = (r_state == IDLE);
    assign filt_out_rts  = (r_state == SEND);
    assign filt_out_data = r_out_data;
    assign ro_sample_cnt = r_sample_cnt;

endmodule

`default_nettype wire

// File: tb/tb_audio_lpf.sv
// ============================================================================
//  Module      : tb_audio_lpf
//  Description : Scoreboard bench for audio_lpf; directed vectors with
//                hand-computed expected outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_lpf;

    logic        clk;
    logic        rst_n;
    logic        rf_filt_en;
    logic [3:0]  rf_filt_shift;
    logic        trig_filt_clr;
    logic [31:0] filt_in_data;
    logic        filt_in_rts;
    logic        filt_in_rtr;
    logic [31:0] filt_out_data;
    logic        filt_out_rts;
    logic        filt_out_rtr;
    logic [15:0] ro_sample_cnt;

    int          n_checks;
    int          n_pass;
    int          n_out;
    logic [31:0] exp_q[$];

    audio_lpf #(.DW(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rf_filt_en    (rf_filt_en),
        .rf_filt_shift (rf_filt_shift),
        .trig_filt_clr (trig_filt_clr),
        .filt_in_data  (filt_in_data),
        .filt_in_rts   (filt_in_rts),
        .filt_in_rtr   (filt_in_rtr),
        .filt_out_data (filt_out_data),
        .filt_out_rts  (filt_out_rts),
        .filt_out_rtr  (filt_out_rtr),
        .ro_sample_cnt (ro_sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && filt_out_rts && filt_out_rtr) begin
            n_out++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                chk("out_data", filt_out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [31:0] exp, input bit push);
        int n;
        n = 0;
        if (push) exp_q.push_back(exp);
        filt_in_data = d;
        filt_in_rts  = 1'b1;
        while (!filt_in_rtr && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) fail_now("in_rtr_wait");
        else tick();
        filt_in_rts = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!filt_in_rtr && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) fail_now("idle_wait");
    endtask

    task automatic pulse_clr();
        trig_filt_clr = 1'b1;
        tick();
        trig_filt_clr = 1'b0;
    endtask

    task automatic send_latency(input logic [31:0] d, input logic [31:0] exp, input string name);
        send(d, exp, 1'b1);
        chk({name, "_rts_calc"}, 32'(filt_out_rts), 32'd0);
        tick();
        chk({name, "_rts_send"}, 32'(filt_out_rts), 32'd1);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_before;
        n_checks = 0;
        n_pass   = 0;
        n_out    = 0;
        rst_n         = 1'b0;
        rf_filt_en    = 1'b0;
        rf_filt_shift = 4'd0;
        trig_filt_clr = 1'b0;
        filt_in_data  = '0;
        filt_in_rts   = 1'b0;
        filt_out_rtr  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_in_rtr",   32'(filt_in_rtr),   32'd1);
        chk("rst_out_rts",  32'(filt_out_rts),  32'd0);
        chk("rst_out_data", filt_out_data,      32'h0);
        chk("rst_cnt",      32'(ro_sample_cnt), 32'h0);

        // Basic filtering, k = 2
        rf_filt_en    = 1'b1;
        rf_filt_shift = 4'd2;
        send_latency(32'h0400FC00, 32'h0100FF00, "basic1");
        send_latency(32'h0400FC00, 32'h01C0FE40, "basic2");
        chk("basic_cnt", 32'(ro_sample_cnt), 32'd2);

        // Bypass loads y, so switching to filter mode is transient-free
        rf_filt_en = 1'b0;
        send(32'h12345678, 32'h12345678, 1'b1);
        wait_idle();
        rf_filt_en    = 1'b1;
        rf_filt_shift = 4'd1;
        send(32'h12345678, 32'h12345678, 1'b1);
        wait_idle();

        // Negative rounding from y = 0
        pulse_clr();
        chk("clr_cnt_zero", 32'(ro_sample_cnt), 32'd0);
        send(32'hFFFF0001, 32'hFFFF0000, 1'b1);
        wait_idle();
        chk("neg_cnt", 32'(ro_sample_cnt), 32'd1);

        // Backpressure: y = {FFFF, 0000}, k = 2
        rf_filt_shift = 4'd2;
        filt_out_rtr  = 1'b0;
        send(32'h0400FC00, 32'h00FFFF00, 1'b1);
        tick();
        filt_in_rts  = 1'b1;
        filt_in_data = 32'hDEADBEEF;
        out_before   = n_out;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rts",    32'(filt_out_rts), 32'd1);
            chk("bp_data",   filt_out_data,     32'h00FFFF00);
            chk("bp_in_rtr", 32'(filt_in_rtr),  32'd0);
            tick();
        end
        filt_in_rts  = 1'b0;
        filt_out_rtr = 1'b1;
        tick();
        tick();
        chk("bp_one_xfer", 32'(n_out - out_before), 32'd1);
        chk("bp_cnt",      32'(ro_sample_cnt),      32'd2);
        chk("bp_idle",     32'(filt_in_rtr),        32'd1);

        // Clear: build y = 0x01C0, then clear and restart from zero
        pulse_clr();
        send(32'h04000400, 32'h01000100, 1'b1);
        wait_idle();
        send(32'h04000400, 32'h01C001C0, 1'b1);
        wait_idle();
        pulse_clr();
        send(32'h04000400, 32'h01000100, 1'b1);
        wait_idle();
        chk("clr_cnt_one", 32'(ro_sample_cnt), 32'd1);

        // Counter wrap: preload near the top instead of 65k transfers
        force dut.r_sample_cnt = 16'hFFFE;
        #1;
        release dut.r_sample_cnt;
        #1;
        chk("wrap_preload", 32'(ro_sample_cnt), 32'h0000FFFE);
        send(32'h04000400, 32'h01C001C0, 1'b1);
        wait_idle();
        chk("wrap_ffff", 32'(ro_sample_cnt), 32'h0000FFFF);
        send(32'h04000400, 32'h02500250, 1'b1);
        wait_idle();
        chk("wrap_zero", 32'(ro_sample_cnt), 32'h0);

        // Reset during SEND drops the in-flight sample
        filt_out_rtr = 1'b0;
        send(32'h11112222, 32'h0, 1'b0);
        tick();
        chk("mid_rts_before", 32'(filt_out_rts), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rts",  32'(filt_out_rts), 32'd0);
        chk("mid_rst_rtr",  32'(filt_in_rtr),  32'd1);
        chk("mid_rst_data", filt_out_data,     32'h0);
        rst_n        = 1'b1;
        filt_out_rtr = 1'b1;
        repeat (5) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
